// File: rtl/pump_sched_pkg.sv
// Shared state, level and fault codes for the two-pump tank scheduler.
package pump_sched_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_LEAD  = 2'b01,
    ST_BOTH  = 2'b10,
    ST_FAULT = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    LVL_LOW     = 2'b00,
    LVL_MID     = 2'b01,
    LVL_INVALID = 2'b10,
    LVL_HIGH    = 2'b11
  } level_e;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_INVALID = 2'b01;
  localparam logic [1:0] FC_PUMPS   = 2'b10;
  localparam logic [1:0] FC_TIMEOUT = 2'b11;

  // Single-pump drive: hand over to the other pump only if the lead alone is faulted.
  function automatic logic [1:0] lead_drive(input logic lead, input logic [1:0] fault);
    logic [1:0] sel;
    sel = lead ? 2'b10 : 2'b01;
    if (fault == sel) sel = ~sel;
    return sel;
  endfunction

endpackage

// File: rtl/pump_scheduler_if.sv
// Sensor/pump-driver bundle between the tank field wiring and the scheduler.
interface pump_scheduler_if;
  logic       enable;
  logic [1:0] level_sensors;
  logic [1:0] pump_fault;
  logic       clear_alarm;
  logic [1:0] pumps;
  logic       lead_pump;
  logic [1:0] state;
  logic       alarm;
  logic [1:0] fault_code;

  modport master (
    output enable, level_sensors, pump_fault, clear_alarm,
    input  pumps, lead_pump, state, alarm, fault_code
  );

  modport slave (
    input  enable, level_sensors, pump_fault, clear_alarm,
    output pumps, lead_pump, state, alarm, fault_code
  );
endinterface

// File: rtl/pump_scheduler_sensor_debounce.sv
// One-bit debouncer: output follows raw after DEBOUNCE_CYCLES consecutive disagreeing cycles.
module sensor_debounce #(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RST_VAL         = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;

  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (raw != deb_q) begin
      if (cnt_q == LAST) deb_d = raw;
      else               cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      deb_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/pump_scheduler.sv
// Two-pump tank scheduler: OFF/LEAD/BOTH sequencing with dwell, lead alternation and alarms.
// Define PUMP_SCHED_TIMEOUT_EN to build the fill counter and fill-timeout fault.
module pump_scheduler
  import pump_sched_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int MIN_DWELL_CYCLES = 64,
  parameter int MAX_FILL_CYCLES  = 4096
) (
  input logic            clk,
  input logic            rst_n,
  pump_scheduler_if.slave bus
);

  localparam int DW = $clog2(MIN_DWELL_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_SAT = DW'(MIN_DWELL_CYCLES);

  logic       deb_i, deb_s;
  level_e     lvl;
  state_e     state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0] pumps_q, pumps_d;
  logic [1:0] code_q, code_d;
  logic       lead_q, lead_d;
  logic       alarm_q, alarm_d;
  logic       invalid, both_flt, dwell_ok, pumping, timeout;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_deb_i (
    .clk(clk), .rst_n(rst_n), .raw(bus.level_sensors[0]), .deb(deb_i)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_deb_s (
    .clk(clk), .rst_n(rst_n), .raw(bus.level_sensors[1]), .deb(deb_s)
  );

  assign lvl      = level_e'({deb_s, deb_i});
  assign invalid  = (lvl == LVL_INVALID);
  assign both_flt = (bus.pump_fault == 2'b11) && (state_q != ST_OFF);
  assign dwell_ok = (dwell_q >= DWELL_SAT);
  assign pumping  = (state_q == ST_LEAD) || (state_q == ST_BOTH);

`ifdef PUMP_SCHED_TIMEOUT_EN
  localparam int FW = $clog2(MAX_FILL_CYCLES + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(MAX_FILL_CYCLES - 1);
  logic [FW-1:0] fill_q, fill_d;

  assign timeout = pumping && (fill_q == FILL_LAST);

  always_comb begin
    fill_d = '0;
    if (pumping && bus.enable) fill_d = fill_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fill_q <= '0;
    else        fill_q <= fill_d;
  end
`else
  logic unused_max_fill;
  assign unused_max_fill = (MAX_FILL_CYCLES > 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    lead_d  = lead_q;
    code_d  = code_q;
    if (state_q == ST_FAULT) begin
      if (bus.clear_alarm && !invalid && !both_flt) begin
        state_d = ST_OFF;
        code_d  = FC_NONE;
      end
    end else if (invalid) begin
      state_d = ST_FAULT;
      code_d  = FC_INVALID;
    end else if (both_flt) begin
      state_d = ST_FAULT;
      code_d  = FC_PUMPS;
    end else if (timeout) begin
      state_d = ST_FAULT;
      code_d  = FC_TIMEOUT;
    end else if (!bus.enable) begin
      state_d = ST_OFF;
    end else if (dwell_ok) begin
      unique case (state_q)
        ST_OFF: begin
          if (lvl == LVL_LOW)      state_d = ST_BOTH;
          else if (lvl == LVL_MID) state_d = ST_LEAD;
        end
        ST_LEAD: begin
          if (lvl == LVL_LOW) state_d = ST_BOTH;
          else if (lvl == LVL_HIGH) begin
            state_d = ST_OFF;
            lead_d  = ~lead_q;
          end
        end
        ST_BOTH: begin
          if (lvl == LVL_MID) state_d = ST_LEAD;
          else if (lvl == LVL_HIGH) begin
            state_d = ST_OFF;
            lead_d  = ~lead_q;
          end
        end
        default: ;
      endcase
    end

    // Pump drive is derived from the next state so it lands on the same edge.
    unique case (state_d)
      ST_LEAD: pumps_d = lead_drive(lead_d, bus.pump_fault);
      ST_BOTH: pumps_d = ~bus.pump_fault;
      default: pumps_d = 2'b00;
    endcase

    alarm_d = (state_d == ST_FAULT);

    if ((state_d != state_q) || !bus.enable) dwell_d = '0;
    else if (dwell_ok)                       dwell_d = dwell_q;
    else                                     dwell_d = dwell_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      dwell_q <= DWELL_SAT;
      pumps_q <= 2'b00;
      lead_q  <= 1'b0;
      alarm_q <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      pumps_q <= pumps_d;
      lead_q  <= lead_d;
      alarm_q <= alarm_d;
      code_q  <= code_d;
    end
  end

  assign bus.pumps      = pumps_q;
  assign bus.lead_pump  = lead_q;
  assign bus.state      = state_q;
  assign bus.alarm      = alarm_q;
  assign bus.fault_code = code_q;

endmodule

// File: tb/tb_pump_scheduler.sv
// Bench for pump_scheduler: directed vector table, edge-exact sequences and random run vs reference model.
module tb_pump_scheduler;

  localparam int DEB   = 4;
  localparam int DWELL = 8;
  localparam int MAXF  = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pump_scheduler_if bus ();

  pump_scheduler #(
    .DEBOUNCE_CYCLES(DEB), .MIN_DWELL_CYCLES(DWELL), .MAX_FILL_CYCLES(MAXF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  int cur_lvl, cur_pf, cur_en, cur_clr;

  // Reference model: plain integers, state 0=OFF 1=LEAD 2=BOTH 3=FAULT.
  int m_deb[2], m_cnt[2];
  int m_state, m_lead, m_dwell, m_fill, m_code, m_pumps, m_alarm;

  task automatic model_reset();
    m_deb[0] = 1; m_deb[1] = 1; m_cnt[0] = 0; m_cnt[1] = 0;
    m_state = 0; m_lead = 0; m_dwell = DWELL; m_fill = 0;
    m_code = 0; m_pumps = 0; m_alarm = 0;
  endtask

  task automatic model_step(input int raw, input int pf, input int en, input int clr);
    int lvl, nxt, toggle, pumping, bad_lvl, bad_pumps, timed_out, b, L, o;
    lvl = m_deb[1] * 2 + m_deb[0];
    for (int i = 0; i < 2; i++) begin
      b = (raw >> i) & 1;
      if (b != m_deb[i]) begin
        m_cnt[i]++;
        if (m_cnt[i] == DEB) begin m_deb[i] = b; m_cnt[i] = 0; end
      end else m_cnt[i] = 0;
    end
    pumping   = (m_state == 1 || m_state == 2);
    bad_lvl   = (lvl == 2);
    bad_pumps = (pf == 3 && m_state != 0);
    timed_out = 0;
`ifdef PUMP_SCHED_TIMEOUT_EN
    timed_out = pumping && (m_fill + 1 == MAXF);
`endif
    nxt = m_state; toggle = 0;
    if (m_state == 3) begin
      if (clr != 0 && !bad_lvl && pf != 3) begin nxt = 0; m_code = 0; end
    end else if (bad_lvl)   begin nxt = 3; m_code = 1; end
    else if (bad_pumps)     begin nxt = 3; m_code = 2; end
    else if (timed_out)     begin nxt = 3; m_code = 3; end
    else if (en == 0)       nxt = 0;
    else if (m_dwell >= DWELL) begin
      // Level names the target: LOW wants BOTH, MID wants LEAD, HIGH wants OFF.
      if (lvl == 0 && m_state != 2)      nxt = 2;
      else if (lvl == 1 && m_state != 1) nxt = 1;
      else if (lvl == 3 && m_state != 0) begin nxt = 0; toggle = 1; end
    end
    m_fill  = (pumping && en != 0) ? m_fill + 1 : 0;
    m_dwell = (nxt != m_state || en == 0) ? 0 : ((m_dwell < DWELL) ? m_dwell + 1 : DWELL);
    if (toggle != 0) m_lead = 1 - m_lead;
    m_state = nxt;
    m_alarm = (nxt == 3) ? 1 : 0;
    if (nxt == 1) begin
      L = m_lead; o = 1 - L;
      if (((pf >> L) & 1) == 1 && ((pf >> o) & 1) == 0) m_pumps = 1 << o;
      else                                             m_pumps = 1 << L;
    end else if (nxt == 2) m_pumps = 3 & ~pf;
    else m_pumps = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int p, input int s, input int l, input int a, input int c);
    chk({tag, ".pumps"},      int'(bus.pumps),      p);
    chk({tag, ".state"},      int'(bus.state),      s);
    chk({tag, ".lead_pump"},  int'(bus.lead_pump),  l);
    chk({tag, ".alarm"},      int'(bus.alarm),      a);
    chk({tag, ".fault_code"}, int'(bus.fault_code), c);
  endtask

  task automatic drive(input int lvl, input int pf, input int en, input int clr);
    cur_lvl = lvl; cur_pf = pf; cur_en = en; cur_clr = clr;
    bus.level_sensors = 2'(lvl);
    bus.pump_fault    = 2'(pf);
    bus.enable        = 1'(en);
    bus.clear_alarm   = 1'(clr);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(cur_lvl, cur_pf, cur_en, cur_clr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(3, 0, 1, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int lvl, pf, en, clr, n;
    int pumps, state, lead, alarm, code;
  } vec_t;

  vec_t tbl[21];

  initial begin
    // lvl pf en clr n | pumps state lead alarm code
    tbl[0]  = '{1, 0, 1, 0, 10, 1, 1, 0, 0, 0};
    tbl[1]  = '{3, 0, 1, 0, 12, 0, 0, 1, 0, 0};
    tbl[2]  = '{1, 0, 1, 0, 14, 2, 1, 1, 0, 0};
    tbl[3]  = '{0, 0, 1, 0, 14, 3, 2, 1, 0, 0};
    tbl[4]  = '{3, 0, 1, 0, 14, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 1, 0,  3, 0, 0, 0, 0, 0};
    tbl[6]  = '{3, 0, 1, 0,  5, 0, 0, 0, 0, 0};
    tbl[7]  = '{2, 0, 1, 0, 10, 0, 3, 0, 1, 1};
    tbl[8]  = '{2, 0, 1, 1,  1, 0, 3, 0, 1, 1};
    tbl[9]  = '{3, 0, 1, 0,  6, 0, 3, 0, 1, 1};
    tbl[10] = '{3, 0, 1, 1,  1, 0, 0, 0, 0, 0};
    tbl[11] = '{3, 0, 1, 0,  2, 0, 0, 0, 0, 0};
    tbl[12] = '{1, 0, 1, 0, 12, 1, 1, 0, 0, 0};
    tbl[13] = '{1, 1, 1, 0,  2, 2, 1, 0, 0, 0};
    tbl[14] = '{1, 3, 1, 0,  2, 0, 3, 0, 1, 2};
    tbl[15] = '{1, 0, 1, 1,  1, 0, 0, 0, 0, 0};
    tbl[16] = '{1, 0, 1, 0, 12, 1, 1, 0, 0, 0};
    tbl[17] = '{1, 0, 0, 0,  1, 0, 0, 0, 0, 0};
    tbl[18] = '{1, 0, 1, 0, 12, 1, 1, 0, 0, 0};
    tbl[19] = '{1, 2, 1, 0,  2, 1, 1, 0, 0, 0};
    tbl[20] = '{0, 2, 1, 0, 12, 1, 2, 0, 0, 0};

    // Reset values, sampled while reset is held.
    rst_n = 1'b0;
    drive(3, 0, 1, 0);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    do_reset();

    foreach (tbl[k]) begin
      drive(tbl[k].lvl, tbl[k].pf, tbl[k].en, tbl[k].clr);
      for (int c = 0; c < tbl[k].n; c++) cycle();
      drive(tbl[k].lvl, tbl[k].pf, tbl[k].en, 0);
      chk_all($sformatf("vec%0d", k), tbl[k].pumps, tbl[k].state, tbl[k].lead, tbl[k].alarm, tbl[k].code);
    end

    // Edge-exact debounce latency and dwell-blocked HIGH after BOTH entry.
    do_reset();
    drive(0, 0, 1, 0);
    for (int e = 1; e <= 4; e++) cycle();
    chk("deb_edge4.pumps", int'(bus.pumps), 0);
    cycle();
    chk("deb_edge5.pumps", int'(bus.pumps), 3);
    chk("deb_edge5.state", int'(bus.state), 2);
    cycle(); cycle();
    drive(3, 0, 1, 0);
    for (int e = 8; e <= 13; e++) cycle();
    chk("dwell_edge13.pumps", int'(bus.pumps), 3);
    cycle();
    chk("dwell_edge14.pumps", int'(bus.pumps), 0);
    chk("dwell_edge14.lead",  int'(bus.lead_pump), 1);

    // Asynchronous reset drops pumps without waiting for a clock edge.
    drive(0, 0, 1, 0);
    for (int e = 0; e < 12; e++) cycle();
    chk("pre_areset.pumps", int'(bus.pumps), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("areset.pumps", int'(bus.pumps), 0);
    chk("areset.state", int'(bus.state), 0);

    // Continuous MID pumping: fill timeout fires at LEAD entry + MAX_FILL_CYCLES.
    do_reset();
    drive(1, 0, 1, 0);
    for (int e = 1; e <= 68; e++) cycle();
    chk("fill_edge68.state", int'(bus.state), 1);
    cycle();
`ifdef PUMP_SCHED_TIMEOUT_EN
    chk("fill_edge69.state", int'(bus.state), 3);
    chk("fill_edge69.code",  int'(bus.fault_code), 3);
`else
    chk("fill_edge69.state", int'(bus.state), 1);
    chk("fill_edge69.code",  int'(bus.fault_code), 0);
`endif

    // Random run compared every cycle with the reference model.
    do_reset();
    begin
      int seg, lvl, pf, en, r;
      seg = 0; lvl = 3; pf = 0; en = 1;
      for (int c = 0; c < 4000; c++) begin
        if (seg == 0) begin
          r   = int'($urandom_range(0, 9));
          lvl = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 3 : 2;
          seg = int'($urandom_range(1, 30));
          pf  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : 0;
          en  = ($urandom_range(0, 19) == 0) ? 0 : 1;
        end
        seg--;
        drive(lvl, pf, en, ($urandom_range(0, 9) == 0) ? 1 : 0);
        cycle();
        chk_all($sformatf("rand%0d", c), m_pumps, m_state, m_lead, m_alarm, m_code);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pump_scheduler.md
# pump_scheduler

Supervisory controller for the two-pump tank: debounces the raw I/S level sensors, sequences pumps B1/B2 through OFF / LEAD / BOTH with lead-pump alternation, enforces a minimum dwell time between pump changes (anti short-cycling), and latches alarms for invalid sensor codes, pump faults and fill timeout. It sits between the level-sensor pins and the pump drivers and replaces direct combinational pump control with a registered, fault-aware sequence.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable cycles needed to accept a raw sensor change.
- MIN_DWELL_CYCLES, 64: minimum cycles spent in a pumping/OFF state before a non-fault transition.
- MAX_FILL_CYCLES, 4096: maximum continuous pumping cycles without reaching HIGH (timeout build only).
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  0 forces OFF immediately, ignoring dwell.
- level_sensors  in  2  raw sensors, bit0 = I (lower), bit1 = S (upper).
- pump_fault  in  2  per-pump driver fault, bit0 = B1, bit1 = B2; level-sensitive.
- clear_alarm  in  1  single-cycle pulse that acknowledges FAULT.
- pumps  out  2  registered pump drive, bit0 = B1, bit1 = B2.
- lead_pump  out  1  0 = B1 leads, 1 = B2 leads.
- state  out  2  current state code.
- alarm  out  1  high while in FAULT.
- fault_code  out  2  00 none, 01 invalid sensors, 10 both pumps faulted, 11 fill timeout.

## Operation
- Debounce: per-bit counter; the debounced bit takes the raw value after DEBOUNCE_CYCLES consecutive cycles of disagreement; any agreement clears the counter. Debounced level: 00 LOW, 01 MID, 11 HIGH, 10 INVALID.
- States: OFF (pumps 00), LEAD (lead pump only), BOTH (available pumps on), FAULT (pumps 00, alarm 1).
- OFF: LOW -> BOTH; MID -> LEAD; HIGH stays.
- LEAD: LOW -> BOTH; HIGH -> OFF and toggle lead_pump.
- BOTH: MID -> LEAD; HIGH -> OFF and toggle lead_pump.
- Non-fault transitions take place only when dwell_cnt >= MIN_DWELL_CYCLES. dwell_cnt clears on state entry and saturates.
- If the lead pump is faulted and the other pump is not, the other pump drives in LEAD. In BOTH, faulted pumps are masked off.
- Any state -> FAULT, ignoring dwell: debounced INVALID (code 01), pump_fault == 11 while not OFF (code 10), or fill timeout (code 11). Priority when several hold: 01 > 10 > 11.
- FAULT -> OFF on clear_alarm only when no fault condition is present. Otherwise FAULT holds and clear_alarm is ignored.
- enable = 0: the next edge forces OFF and clears dwell_cnt and the fill counter. FAULT still has priority over enable.
- Reset values: debounced level 11 (HIGH, safe), state OFF, pumps 00, lead_pump 0, alarm 0, fault_code 00, dwell_cnt saturated, all counters 0.

## Timing
- pumps, state, alarm and fault_code are all registered and update on the same edge.
- A raw change that is stable from before edge 1 appears as the debounced level at edge DEBOUNCE_CYCLES. State and pumps follow at edge DEBOUNCE_CYCLES+1 if dwell is satisfied.
- If dwell is not satisfied, the transition occurs on the first edge where dwell_cnt >= MIN_DWELL_CYCLES, provided the level still requests it.
- lead_pump toggles on the same edge as the entry to OFF.
- The fill counter increments every edge in LEAD or BOTH and clears in OFF. The timeout fires on the edge where the count reaches MAX_FILL_CYCLES.
- Reset assertion mid-operation drops pumps to 00 asynchronously.

## Configuration
- PUMP_SCHED_TIMEOUT_EN defined: fill counter and fault code 11 are present.
- PUMP_SCHED_TIMEOUT_EN undefined: no fill counter, code 11 is never produced, and MAX_FILL_CYCLES is unused.

## Structure
- pump_sched_pkg holds the state codes (OFF = 00, LEAD = 01, BOTH = 10, FAULT = 11), the level codes and the fault_code constants.
- Sub-module sensor_debounce: one bit, parameter DEBOUNCE_CYCLES, with its own reset value. It is instantiated twice with reset value 1.
- The top level contains the FSM, dwell counter, fill counter and lead register.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4, MIN_DWELL_CYCLES = 8, MAX_FILL_CYCLES = 64.
- Reset, then raw 00: debounced LOW at edge 4, pumps 11 and state BOTH at edge 5. Then raw 11: pumps 00 and lead_pump 1 once dwell >= 8.
- From OFF, raw 01: pumps 01 (B1 lead). Cycle through HIGH and back to 01: pumps 10 (B2 now leads).
- Raw glitch to 00 for 3 cycles from HIGH: no debounced change, pumps stay 00.
- LOW then HIGH two cycles after BOTH entry: pumps stay 11 until dwell_cnt reaches 8, then 00.
- Raw 10 stable: FAULT, pumps 00, alarm 1, fault_code 01. clear_alarm while still 10 is ignored. Raw back to 11 plus clear_alarm -> OFF, alarm 0.
- In LEAD with pump_fault = 01: pumps 10. pump_fault = 11: fault_code 10. Hold MID for 64 cycles with the macro defined: fault_code 11.
